leiwand_rv32_pipe_ram: RTL and testbench
========================================

# leiwand_rv32_pipe_ram

Pipelined, parametrised single-port Wishbone B4 RAM slave for the leiwand_rv32 SoC.
- Accepts one request per clock and responds in order after a fixed, configurable read latency.
- Supports byte, half and full-word writes on 32- or 64-bit words.
- Flags misaligned or out-of-range accesses with o_err instead of corrupting memory.
- Sits on the core's data/instruction bus as the main scratch memory.

## Interface
- MEM_WIDTH, 32: word width in bits; legal values 32 or 64; LANES = MEM_WIDTH/8.
- MEM_SIZE, 1024: depth in words.
- RD_LATENCY, 1: cycles from request acceptance to ack/err; legal range 1..4.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_cyc  in  1  bus cycle active.
- i_stb  in  1  request strobe.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  MEM_WIDTH  byte address.
- i_dat  in  MEM_WIDTH  write data; sub-word data is right-aligned.
- i_dat_wr_size  in  4  access size in bytes: 1, 2, 4 or 8. Any other value means a full word.
- o_dat  out  MEM_WIDTH  read data; valid only while o_ack=1, otherwise 0.
- o_ack  out  1  successful completion, one cycle per request.
- o_err  out  1  failed completion, one cycle per request; mutually exclusive with o_ack.
- o_stall  out  1  slave cannot accept a request this cycle.

## Operation
- States: INIT and RUN.
  - Reset enters INIT.
  - INIT -> RUN when initialisation is done (see Configuration). RUN is terminal until reset.
- Acceptance: a request is accepted on a rising edge with i_cyc & i_stb & !o_stall. In RUN, o_stall=0.
- Address decode:
  - lane = i_addr[log2(LANES)-1:0].
  - index = i_addr >> log2(LANES).
- Error conditions; on error nothing is written:
  - index >= MEM_SIZE.
  - Size does not divide lane (half at odd lane, word at lane not multiple of 4).
  - Size 8 with MEM_WIDTH=32.
- Writes:
  - Committed on the acceptance edge.
  - Byte-enable mask = size bytes starting at lane.
  - Data lane k of the word takes byte (k - lane) of i_dat.
  - Bytes outside the mask are unchanged.
- Reads:
  - Full word sampled at acceptance.
  - If a write to the same index is accepted on the same edge, it is a separate earlier request, and a read accepted on the following edge returns the written value. Read-after-write is always coherent.
- Responses:
  - Every accepted request (read or write) yields exactly one o_ack or o_err pulse exactly RD_LATENCY cycles after acceptance, in issue order.
  - Back-to-back requests give back-to-back responses.
- Abort: if i_cyc is low on any cycle, all in-flight responses are discarded; no ack/err is issued for them. Memory writes already committed stay committed.

## Timing
- Reset values: o_ack=0, o_err=0, o_dat=0, o_stall=1. Pipeline valid bits are cleared.
- Reset asserted mid-transfer: on the next edge all outputs return to reset values and in-flight responses are dropped. Memory contents are preserved unless the zero-init build sweeps them.
- INIT without the macro lasts exactly 1 cycle, so o_stall falls 2 cycles after i_rst deasserts.
- Throughput is 1 request/cycle with no stall in RUN.
- Latency is exactly RD_LATENCY cycles; o_dat is registered.
- Simultaneous new acceptance and response emission on the same cycle is normal pipelined operation.

## Configuration
- LEIWAND_RV32_RAM_INIT_ZERO_EN
  - Defined: INIT writes one word of zeros per cycle over indexes 0..MEM_SIZE-1, holding o_stall=1. RUN is entered after MEM_SIZE cycles, so all words read 0 after reset.
  - Undefined: INIT lasts 1 cycle and memory content is undefined (simulation X / FPGA init).

## Structure
- Shared package/header with:
  - state encodings (INIT=0, RUN=1);
  - size codes (1, 2, 4, 8);
  - the HIGH_BIT_TO_FIT width helper (from helper.v).
- Sub-module leiwand_rv32_ram_resp_pipe:
  - RD_LATENCY-deep shift register of {valid, err, data};
  - synchronous clear on i_rst or !i_cyc;
  - drives o_ack = valid & !err, o_err = valid & err, o_dat = (valid & !err) ? data : 0.
- Top holds the memory array, decode, error check, byte-enable write and INIT sequencer.

## Test plan
- Reset then idle: o_stall=1 during reset, o_stall=0 two cycles after reset release, o_ack=o_err=0 throughout.
- MEM_WIDTH=32, RD_LATENCY=2:
  - Write 0xAABBCCDD to addr 0x10, then read 0x10 on the next cycle.
  - Required: ack at acceptance+2 for each request; read returns 0xAABBCCDD.
- Sub-word writes to word 0x10 (holding 0xAABBCCDD):
  - byte 0x11 at 0x13 -> 0x11BBCCDD;
  - half 0x2233 at 0x10 -> 0x11BB2233.
- Half-word at 0x11, and word at 4*MEM_SIZE:
  - Required: o_err pulse and no o_ack for each.
  - A subsequent read shows memory unchanged.
- Pipelined burst of 4 reads on consecutive cycles, then i_cyc dropped for one cycle after the second response:
  - Exactly 2 acks.
  - Remaining responses are squashed.
- With LEIWAND_RV32_RAM_INIT_ZERO_EN and MEM_SIZE=16:
  - o_stall stays high for 16 INIT cycles.
  - A read of index 15 then returns 0 even after it was written before a reset.

Source files
------------

// File: rtl/leiwand_rv32_pipe_ram_pkg.sv
// Shared definitions for the leiwand_rv32 pipelined RAM slave: state encodings,
// access size codes and the HIGH_BIT_TO_FIT width helper.
package leiwand_rv32_pipe_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ram_state_e;

  localparam logic [3:0] SZ_BYTE  = 4'd1;
  localparam logic [3:0] SZ_HALF  = 4'd2;
  localparam logic [3:0] SZ_WORD  = 4'd4;
  localparam logic [3:0] SZ_DWORD = 4'd8;

  // Index of the highest bit needed to address n items (0 for n <= 1).
  function automatic int HIGH_BIT_TO_FIT(input int n);
    return (n <= 1) ? 0 : $clog2(n) - 1;
  endfunction

endpackage

// File: rtl/leiwand_rv32_pipe_ram_if.sv
// Wishbone B4 pipelined bus bundle between the core and the scratch RAM.
interface leiwand_rv32_pipe_ram_if #(
  parameter int MEM_WIDTH = 32
);
  logic                 i_cyc;
  logic                 i_stb;
  logic                 i_we;
  logic [MEM_WIDTH-1:0] i_addr;
  logic [MEM_WIDTH-1:0] i_dat;
  logic [3:0]           i_dat_wr_size;
  logic [MEM_WIDTH-1:0] o_dat;
  logic                 o_ack;
  logic                 o_err;
  logic                 o_stall;

  modport slave (
    input  i_cyc, i_stb, i_we, i_addr, i_dat, i_dat_wr_size,
    output o_dat, o_ack, o_err, o_stall
  );

  modport master (
    output i_cyc, i_stb, i_we, i_addr, i_dat, i_dat_wr_size,
    input  o_dat, o_ack, o_err, o_stall
  );
endinterface

// File: rtl/leiwand_rv32_ram_resp_pipe.sv
// Fixed-latency response pipeline: carries {valid, err, data} of each accepted
// request and emits exactly one ack or err pulse at the far end.
module leiwand_rv32_ram_resp_pipe #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cyc,
  input  logic         i_valid,
  input  logic         i_err,
  input  logic [W-1:0] i_data,
  output logic         o_ack,
  output logic         o_err,
  output logic [W-1:0] o_dat
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] err_q;
  logic [W-1:0]     data_q [DEPTH];

  // Dropping i_cyc aborts the bus cycle, so every in-flight response dies.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_cyc) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    err_q[0]  <= i_err;
    data_q[0] <= i_data;
    for (int i = 1; i < DEPTH; i++) begin
      err_q[i]  <= err_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  assign o_ack = valid_q[DEPTH-1] & ~err_q[DEPTH-1];
  assign o_err = valid_q[DEPTH-1] &  err_q[DEPTH-1];
  assign o_dat = o_ack ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/leiwand_rv32_pipe_ram.sv
// Pipelined single-port Wishbone B4 scratch RAM with byte/half/word writes.
// Optional LEIWAND_RV32_RAM_INIT_ZERO_EN: INIT sweeps the whole array to zero.
//
// state   | meaning
// ST_INIT | post-reset initialisation, o_stall held high
// ST_RUN  | normal operation, one request per cycle, terminal until reset
module leiwand_rv32_pipe_ram
  import leiwand_rv32_pipe_ram_pkg::*;
#(
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int RD_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  leiwand_rv32_pipe_ram_if.slave bus
);

  localparam int LANES     = MEM_WIDTH / 8;
  localparam int LANE_BITS = HIGH_BIT_TO_FIT(LANES) + 1;
  localparam int IDX_W     = HIGH_BIT_TO_FIT(MEM_SIZE) + 1;

  logic [MEM_WIDTH-1:0] mem [MEM_SIZE];

  ram_state_e state_q, state_d;
  logic       stall_q;

  logic [LANE_BITS-1:0] lane;
  logic [MEM_WIDTH-1:0] addr_idx;
  logic [IDX_W-1:0]     idx;
  logic                 in_range;
  int                   size_b;
  int                   lane_i;
  logic                 acc_err;
  logic [LANES-1:0]     be;
  logic [MEM_WIDTH-1:0] wdat;
  logic [MEM_WIDTH-1:0] rd_word;
  logic                 accept;
  logic                 wr_en;

`ifdef LEIWAND_RV32_RAM_INIT_ZERO_EN
  logic [IDX_W-1:0] init_idx_q;
  logic             init_wr;

  assign init_wr = (state_q == ST_INIT) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst)        init_idx_q <= '0;
    else if (init_wr) init_idx_q <= init_idx_q + 1'b1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      stall_q <= 1'b1;
    end else begin
      state_q <= state_d;
      stall_q <= (state_q != ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef LEIWAND_RV32_RAM_INIT_ZERO_EN
      ST_INIT: if (init_idx_q == IDX_W'(MEM_SIZE - 1)) state_d = ST_RUN;
`else
      ST_INIT: state_d = ST_RUN;
`endif
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.o_stall = stall_q;

  assign lane     = bus.i_addr[LANE_BITS-1:0];
  assign lane_i   = int'(lane);
  assign addr_idx = bus.i_addr >> LANE_BITS;
  assign in_range = addr_idx < MEM_WIDTH'(MEM_SIZE);
  assign idx      = addr_idx[IDX_W-1:0];

  always_comb begin
    size_b = LANES;
    case (bus.i_dat_wr_size)
      SZ_BYTE:  size_b = 1;
      SZ_HALF:  size_b = 2;
      SZ_WORD:  size_b = 4;
      SZ_DWORD: size_b = 8;
      default:  size_b = LANES;
    endcase
  end

  // Oversized accesses are rejected before the alignment mask could truncate.
  always_comb begin
    acc_err = 1'b0;
    if (!in_range)                                        acc_err = 1'b1;
    else if (size_b > LANES)                              acc_err = 1'b1;
    else if ((lane & LANE_BITS'(size_b - 1)) != '0)       acc_err = 1'b1;
  end

  always_comb begin
    be = '0;
    for (int k = 0; k < LANES; k++)
      be[k] = (k >= lane_i) && (k < lane_i + size_b);
  end

  assign wdat = bus.i_dat << (8 * lane_i);

  assign accept = bus.i_cyc && bus.i_stb && !stall_q && !i_rst;
  assign wr_en  = accept && bus.i_we && !acc_err;

  // Reads see the array before this edge's commit; only one request per edge.
  assign rd_word = in_range ? mem[idx] : '0;

  always_ff @(posedge i_clk) begin
`ifdef LEIWAND_RV32_RAM_INIT_ZERO_EN
    if (init_wr) mem[init_idx_q] <= '0;
    else
`endif
    if (wr_en) begin
      for (int k = 0; k < LANES; k++)
        if (be[k]) mem[idx][8*k +: 8] <= wdat[8*k +: 8];
    end
  end

  leiwand_rv32_ram_resp_pipe #(
    .W     (MEM_WIDTH),
    .DEPTH (RD_LATENCY)
  ) u_resp_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cyc   (bus.i_cyc),
    .i_valid (accept),
    .i_err   (acc_err),
    .i_data  ((bus.i_we || acc_err) ? '0 : rd_word),
    .o_ack   (bus.o_ack),
    .o_err   (bus.o_err),
    .o_dat   (bus.o_dat)
  );

endmodule

// File: tb/tb_leiwand_rv32_pipe_ram.sv
// Directed self-checking bench for leiwand_rv32_pipe_ram (32-bit, latency 2).
module tb_leiwand_rv32_pipe_ram;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  int   acks_seen;

  always #5 i_clk = ~i_clk;

  leiwand_rv32_pipe_ram_if #(.MEM_WIDTH(32)) bus ();

  leiwand_rv32_pipe_ram #(
    .MEM_WIDTH  (32),
    .MEM_SIZE   (1024),
    .RD_LATENCY (2)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] dat,
                       input logic [3:0] size);
    bus.i_cyc         = 1'b1;
    bus.i_stb         = 1'b1;
    bus.i_we          = we;
    bus.i_addr        = addr;
    bus.i_dat         = dat;
    bus.i_dat_wr_size = size;
  endtask

  task automatic idle;
    bus.i_stb = 1'b0;
    bus.i_we  = 1'b0;
  endtask

  // One isolated request: nothing after the acceptance edge, the response one
  // edge later, and silence again afterwards.
  task automatic single(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] dat, input logic [3:0] size,
                        input logic exp_err, input logic [31:0] exp_dat);
    drive(we, addr, dat, size);
    tick;
    idle;
    chk({tag, "_early"}, {30'd0, bus.o_ack, bus.o_err}, 32'd0);
    tick;
    chk({tag, "_ack"}, {31'd0, bus.o_ack}, {31'd0, !exp_err});
    chk({tag, "_err"}, {31'd0, bus.o_err}, {31'd0, exp_err});
    chk({tag, "_dat"}, bus.o_dat, exp_dat);
    tick;
    chk({tag, "_quiet"}, {30'd0, bus.o_ack, bus.o_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.i_cyc = 1'b0;
    bus.i_stb = 1'b0;
    bus.i_we  = 1'b0;
    bus.i_addr = '0;
    bus.i_dat  = '0;
    bus.i_dat_wr_size = 4'd4;

    tick;
    tick;
    chk("rst_stall", {31'd0, bus.o_stall}, 32'd1);
    chk("rst_ack",   {31'd0, bus.o_ack},   32'd0);
    chk("rst_err",   {31'd0, bus.o_err},   32'd0);
    chk("rst_dat",   bus.o_dat,            32'd0);

    i_rst = 1'b0;
    tick;
    chk("init_stall_1", {31'd0, bus.o_stall}, 32'd1);
    tick;
    chk("init_stall_2", {31'd0, bus.o_stall}, 32'd0);
    chk("idle_resp", {30'd0, bus.o_ack, bus.o_err}, 32'd0);

    // Back-to-back write then read of the same word.
    drive(1'b1, 32'h10, 32'hAABBCCDD, 4'd4);
    tick;
    chk("rw_w_early", {31'd0, bus.o_ack}, 32'd0);
    drive(1'b0, 32'h10, 32'h0, 4'd4);
    tick;
    idle;
    chk("rw_w_ack", {31'd0, bus.o_ack}, 32'd1);
    tick;
    chk("rw_r_ack", {31'd0, bus.o_ack}, 32'd1);
    chk("rw_r_dat", bus.o_dat, 32'hAABBCCDD);
    tick;
    chk("rw_quiet", {30'd0, bus.o_ack, bus.o_err}, 32'd0);

    single("wr_b13", 1'b1, 32'h13, 32'h00000011, 4'd1, 1'b0, 32'h0);
    single("rd_b13", 1'b0, 32'h10, 32'h0,        4'd4, 1'b0, 32'h11BBCCDD);
    single("wr_h10", 1'b1, 32'h10, 32'h00002233, 4'd2, 1'b0, 32'h0);
    single("rd_h10", 1'b0, 32'h10, 32'h0,        4'd4, 1'b0, 32'h11BB2233);

    single("wr_h11_mis", 1'b1, 32'h11, 32'h0000FFFF, 4'd2, 1'b1, 32'h0);
    single("rd_after_mis", 1'b0, 32'h10, 32'h0, 4'd4, 1'b0, 32'h11BB2233);
    single("wr_w12_mis", 1'b1, 32'h12, 32'hFFFFFFFF, 4'd4, 1'b1, 32'h0);
    single("wr_d8_32b", 1'b1, 32'h10, 32'hFFFFFFFF, 4'd8, 1'b1, 32'h0);
    single("rd_after_d8", 1'b0, 32'h10, 32'h0, 4'd4, 1'b0, 32'h11BB2233);

    // Out of range must not alias onto index 0.
    single("wr_w0", 1'b1, 32'h0, 32'h12345678, 4'd4, 1'b0, 32'h0);
    single("wr_oor", 1'b1, 32'h1000, 32'hDEADBEEF, 4'd4, 1'b1, 32'h0);
    single("rd_oor", 1'b0, 32'h1000, 32'h0, 4'd4, 1'b1, 32'h0);
    single("rd_w0", 1'b0, 32'h0, 32'h0, 4'd4, 1'b0, 32'h12345678);

    // Undefined size code acts as a full word.
    single("wr_sz0", 1'b1, 32'h14, 32'h01020304, 4'd0, 1'b0, 32'h0);
    single("rd_sz0", 1'b0, 32'h14, 32'h0, 4'd4, 1'b0, 32'h01020304);
    single("wr_b15", 1'b1, 32'h15, 32'h000000A5, 4'd1, 1'b0, 32'h0);
    single("rd_b15", 1'b0, 32'h14, 32'h0, 4'd4, 1'b0, 32'h0102A504);

    // Burst of four reads, cycle aborted once two responses have been taken.
    acks_seen = 0;
    drive(1'b0, 32'h0, 32'h0, 4'd4);
    tick;
    drive(1'b0, 32'h10, 32'h0, 4'd4);
    tick;
    if (bus.i_cyc && bus.o_ack) acks_seen++;
    chk("burst_r0_dat", bus.o_dat, 32'h12345678);
    drive(1'b0, 32'h14, 32'h0, 4'd4);
    tick;
    if (bus.i_cyc && bus.o_ack) acks_seen++;
    chk("burst_r1_dat", bus.o_dat, 32'h11BB2233);
    drive(1'b0, 32'h10, 32'h0, 4'd4);
    tick;
    idle;
    bus.i_cyc = 1'b0;
    tick;
    bus.i_cyc = 1'b1;
    chk("burst_squash_1", {30'd0, bus.o_ack, bus.o_err}, 32'd0);
    if (bus.i_cyc && bus.o_ack) acks_seen++;
    tick;
    chk("burst_squash_2", {30'd0, bus.o_ack, bus.o_err}, 32'd0);
    if (bus.i_cyc && bus.o_ack) acks_seen++;
    chk("burst_ack_count", acks_seen, 32'd2);

    // Reset in the middle of a request drops its response, keeps memory.
    drive(1'b0, 32'h10, 32'h0, 4'd4);
    tick;
    idle;
    i_rst = 1'b1;
    tick;
    chk("midrst_resp",  {30'd0, bus.o_ack, bus.o_err}, 32'd0);
    chk("midrst_stall", {31'd0, bus.o_stall}, 32'd1);
    i_rst = 1'b0;
    tick;
    tick;
    chk("midrst_run", {31'd0, bus.o_stall}, 32'd0);
    single("rd_after_rst", 1'b0, 32'h10, 32'h0, 4'd4, 1'b0, 32'h11BB2233);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
